icmp_echo_filter: RTL and testbench
===================================

Name: icmp_echo_filter

Overview:
- Ingress stage directly upstream of the ICMP echo responder on the 32-bit Avalon-ST path.
- Store-and-decides the first 6 words (IPv4 header + first ICMP word) of each packet.
- Forwards only IPv4 (no options) ICMP Echo Requests that fit the responder's 32-word buffer; silently drops everything else.
- Keeps pass/drop packet counters.

Parameters:
- MAX_BYTES, 128: largest IPv4 total_length forwarded; larger packets are dropped.
- CNT_W, 16: width of the pass/drop counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- stream_in_data  in  32  byte0 in [7:0] … byte3 in [31:24].
- stream_in_empty  in  2  empty bytes on the eop word.
- stream_in_valid  in  1
- stream_in_startofpacket  in  1
- stream_in_endofpacket  in  1
- stream_in_ready  out  1
- stream_out_data  out  32
- stream_out_empty  out  2
- stream_out_valid  out  1
- stream_out_startofpacket  out  1
- stream_out_endofpacket  out  1
- stream_out_ready  in  1
- pkt_passed_count  out  CNT_W  packets forwarded; saturating.
- pkt_dropped_count  out  CNT_W  packets dropped; saturating.

Behaviour:
- Reset (reset_n low at clk edge):
  - state=S_HDR; header count=0; hdr_eop=0.
  - All stream_out_* = 0; stream_in_ready=0; both counters = 0.
- Input transfer: stream_in_valid && stream_in_ready.
- Output transfer: stream_out_valid && stream_out_ready.
- Output stage is a single register. It may load only when !stream_out_valid || stream_out_ready. Data, empty, sop and eop are held while valid && !ready.
- S_HDR:
  - stream_in_ready=1.
  - Words are written to hdr_buf[0..5].
  - With count=0, non-sop words are discarded; this is the recovery path after a mid-packet reset.
  - A sop word arriving at count>0 restarts the capture at index 0.
  - An eop within words 0..5 sets hdr_eop.
  - Go to S_DECIDE after word 5 is accepted, or on an earlier eop.
- S_DECIDE (1 cycle, stream_in_ready=0). Pass requires all of:
  - hdr_eop=0
  - hdr_buf[0][7:0]==8'h45
  - total_len={hdr_buf[0][23:16],hdr_buf[0][31:24]} <= MAX_BYTES
  - hdr_buf[2][15:8]==8'd1 (protocol ICMP)
  - hdr_buf[5][7:0]==8'd8 (echo request)
- S_DECIDE transitions:
  - Pass → S_REPLAY.
  - Fail with hdr_eop=1 → dropped_count++, then S_HDR.
  - Fail with hdr_eop=0 → dropped_count++, then S_DROP.
- S_REPLAY (stream_in_ready=0):
  - Drive hdr_buf[0..5] in order; sop=1 on word 0 only; eop=0; empty=0.
  - After word 5 is loaded into the output register → S_PASS.
- S_PASS:
  - stream_in_ready = !stream_out_valid || stream_out_ready.
  - Each accepted input word loads the output register with data, empty and eop; sop=0.
  - When the eop word is accepted: passed_count++, then S_HDR.
  - stream_out_valid drops on the cycle after the last output transfer if nothing new loads.
- S_DROP: stream_in_ready=1; discard words until the eop word is accepted, then S_HDR.
- Latency: first stream_out_valid rises 2 cycles after word 5 is accepted (1 cycle DECIDE, then register load).
- Back-to-back packets: no idle cycle is required between an eop and the next sop accepted in S_HDR.
- Counters saturate at all-ones and never wrap.
- Reset mid-packet: output is cleared immediately; no partial eop is emitted. The upstream remainder is discarded by the S_HDR sop rule.
- Packets shorter than 6 words: never forwarded; counted as dropped.

Decomposition:
- Package icmp_pkg holds:
  - the state enum;
  - IPV4_VER_IHL=8'h45, IP_PROTO_ICMP=8'd1, ICMP_ECHO_REQ=8'd8, ICMP_ECHO_REPLY=8'd0;
  - HDR_WORDS=6;
  - word/byte-lane offsets for total_len, protocol and ICMP type.
- One combinational sub-module, icmp_hdr_check: inputs are the 6 header words, hdr_eop and MAX_BYTES; output is pass. It is reusable by the responder's bench.

Test Plan:
- 84-byte echo request (21 words, ver 0x45, proto 1, type 8, eop empty=0), out_ready=1 → identical 21 words out, sop on word 0, eop on word 20; passed=1, dropped=0.
- Same packet with out_ready toggling 1/0 every cycle → byte-identical output, no duplicated or lost words, in_ready never high while output is stalled.
- UDP packet (proto 17, 20 words) followed back-to-back by a valid echo request → first dropped (dropped=1), second forwarded intact, in_ready=1 throughout the drop.
- Echo request with total_len=200 (>128) → dropped; ICMP type 0 (reply) → dropped; dropped=2.
- 4-word packet with eop on word 3 → dropped without entering S_DROP; the next valid packet is forwarded.
- reset_n low for 1 cycle during the 10th output word of a 21-word pass, with upstream continuing the old packet then sending a new one → outputs 0 after reset, old tail ignored, new packet forwarded; counters=0 then passed=1.

Source files
------------

// File: rtl/icmp_pkg.sv
// Shared types and IPv4/ICMP field locations for the ICMP echo filter and responder.
// Header words are little-endian byte lanes: byte0 of each word sits in bits [7:0].
package icmp_pkg;

  typedef enum logic [2:0] {
    S_HDR,
    S_DECIDE,
    S_REPLAY,
    S_PASS,
    S_DROP
  } state_e;

  localparam logic [7:0] IPV4_VER_IHL    = 8'h45;
  localparam logic [7:0] IP_PROTO_ICMP   = 8'd1;
  localparam logic [7:0] ICMP_ECHO_REQ   = 8'd8;
  localparam logic [7:0] ICMP_ECHO_REPLY = 8'd0;

  localparam int HDR_WORDS = 6;

  // total_len is big-endian: byte2 (bits 23:16) is the high byte, byte3 (bits 31:24) the low byte
  localparam int VER_IHL_WORD     = 0;
  localparam int VER_IHL_LSB      = 0;
  localparam int TOTAL_LEN_WORD   = 0;
  localparam int TOTAL_LEN_HI_LSB = 16;
  localparam int TOTAL_LEN_LO_LSB = 24;
  localparam int PROTO_WORD       = 2;
  localparam int PROTO_LSB        = 8;
  localparam int ICMP_TYPE_WORD   = 5;
  localparam int ICMP_TYPE_LSB    = 0;

endpackage

// File: rtl/icmp_hdr_check.sv
// Combinational pass/drop decision over the captured IPv4 header plus first ICMP word.
module icmp_hdr_check
  import icmp_pkg::*;
(
  input  logic [HDR_WORDS-1:0][31:0] hdr_words_i,
  input  logic                       hdr_eop_i,
  input  logic [15:0]                max_bytes_i,
  output logic                       pass_o
);

  logic [15:0] total_len;
  logic        unused_bits;

  assign total_len = {hdr_words_i[TOTAL_LEN_WORD][TOTAL_LEN_HI_LSB +: 8],
                      hdr_words_i[TOTAL_LEN_WORD][TOTAL_LEN_LO_LSB +: 8]};

  // Most header bytes do not take part in the decision.
  assign unused_bits = ^hdr_words_i;

  assign pass_o = !hdr_eop_i
               && (hdr_words_i[VER_IHL_WORD][VER_IHL_LSB +: 8] == IPV4_VER_IHL)
               && (total_len <= max_bytes_i)
               && (hdr_words_i[PROTO_WORD][PROTO_LSB +: 8] == IP_PROTO_ICMP)
               && (hdr_words_i[ICMP_TYPE_WORD][ICMP_TYPE_LSB +: 8] == ICMP_ECHO_REQ);

endmodule

// File: rtl/icmp_echo_filter.sv
// Store-and-decide ingress filter: buffers the first 6 words, forwards only small
// option-less IPv4 ICMP echo requests, drops everything else and counts both.
module icmp_echo_filter
  import icmp_pkg::*;
#(
  parameter int MAX_BYTES = 128,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      stream_in_data,
  input  logic [1:0]       stream_in_empty,
  input  logic             stream_in_valid,
  input  logic             stream_in_startofpacket,
  input  logic             stream_in_endofpacket,
  output logic             stream_in_ready,
  output logic [31:0]      stream_out_data,
  output logic [1:0]       stream_out_empty,
  output logic             stream_out_valid,
  output logic             stream_out_startofpacket,
  output logic             stream_out_endofpacket,
  input  logic             stream_out_ready,
  output logic [CNT_W-1:0] pkt_passed_count,
  output logic [CNT_W-1:0] pkt_dropped_count
);

  localparam logic [2:0]  LAST_HDR = 3'(HDR_WORDS - 1);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_BYTES);

  state_e                      state_q, state_d;
  logic [2:0]                  cnt_q, cnt_d;
  logic                        hdr_eop_q, hdr_eop_d;
  logic [HDR_WORDS-1:0][31:0]  hdr_buf_q;
  logic                        hdr_we;
  logic [2:0]                  hdr_widx;
  logic [31:0]                 out_data_q, out_data_d;
  logic [1:0]                  out_empty_q, out_empty_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_sop_q, out_sop_d;
  logic                        out_eop_q, out_eop_d;
  logic [CNT_W-1:0]            pass_cnt_q, drop_cnt_q;
  logic                        pass_inc, drop_inc;
  logic                        load_ok, in_rdy, in_xfer, hdr_pass;

  icmp_hdr_check u_hdr_check (
    .hdr_words_i (hdr_buf_q),
    .hdr_eop_i   (hdr_eop_q),
    .max_bytes_i (MAX_LEN),
    .pass_o      (hdr_pass)
  );

  assign load_ok = !out_valid_q || stream_out_ready;

  always_comb begin
    in_rdy = 1'b0;
    case (state_q)
      S_HDR, S_DROP: in_rdy = 1'b1;
      S_PASS:        in_rdy = load_ok;
      default:       in_rdy = 1'b0;
    endcase
  end

  // Held low while in reset so nothing is accepted that the FSM would ignore.
  assign stream_in_ready = reset_n && in_rdy;
  assign in_xfer         = stream_in_valid && stream_in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_eop_d   = hdr_eop_q;
    hdr_we      = 1'b0;
    hdr_widx    = cnt_q;
    out_valid_d = out_valid_q && !stream_out_ready;
    out_data_d  = out_data_q;
    out_empty_d = out_empty_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    pass_inc    = 1'b0;
    drop_inc    = 1'b0;
    case (state_q)
      S_HDR: begin
        if (in_xfer && stream_in_startofpacket) begin
          hdr_we    = 1'b1;
          hdr_widx  = 3'd0;
          cnt_d     = 3'd1;
          hdr_eop_d = stream_in_endofpacket;
          if (stream_in_endofpacket) state_d = S_DECIDE;
        end else if (in_xfer && cnt_q != 3'd0) begin
          hdr_we    = 1'b1;
          cnt_d     = cnt_q + 3'd1;
          hdr_eop_d = stream_in_endofpacket;
          if (stream_in_endofpacket || cnt_q == LAST_HDR) state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        cnt_d = 3'd0;
        if (hdr_pass) begin
          state_d = S_REPLAY;
        end else begin
          drop_inc = 1'b1;
          state_d  = hdr_eop_q ? S_HDR : S_DROP;
        end
      end
      S_REPLAY: begin
        if (load_ok) begin
          out_valid_d = 1'b1;
          out_data_d  = hdr_buf_q[cnt_q];
          out_empty_d = 2'd0;
          out_sop_d   = (cnt_q == 3'd0);
          out_eop_d   = 1'b0;
          if (cnt_q == LAST_HDR) begin
            cnt_d   = 3'd0;
            state_d = S_PASS;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_PASS: begin
        if (in_xfer) begin
          out_valid_d = 1'b1;
          out_data_d  = stream_in_data;
          out_empty_d = stream_in_empty;
          out_sop_d   = 1'b0;
          out_eop_d   = stream_in_endofpacket;
          if (stream_in_endofpacket) begin
            pass_inc = 1'b1;
            state_d  = S_HDR;
          end
        end
      end
      S_DROP: begin
        if (in_xfer && stream_in_endofpacket) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_HDR;
      cnt_q       <= 3'd0;
      hdr_eop_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_empty_q <= 2'd0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      pass_cnt_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_eop_q   <= hdr_eop_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_empty_q <= out_empty_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      if (pass_inc && pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + 1'b1;
      if (drop_inc && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  // Header storage needs no reset: it is only read after a full capture.
  always_ff @(posedge clk) begin
    if (hdr_we) hdr_buf_q[hdr_widx] <= stream_in_data;
  end

  assign stream_out_data          = out_data_q;
  assign stream_out_empty         = out_empty_q;
  assign stream_out_valid         = out_valid_q;
  assign stream_out_startofpacket = out_sop_q;
  assign stream_out_endofpacket   = out_eop_q;
  assign pkt_passed_count         = pass_cnt_q;
  assign pkt_dropped_count        = drop_cnt_q;

endmodule

// File: tb/tb_icmp_echo_filter.sv
// Directed bench for icmp_echo_filter: byte-level packet model plus per-word output scoreboard.
module tb_icmp_echo_filter;

  logic        clk;
  logic        reset_n;
  logic [31:0] stream_in_data;
  logic [1:0]  stream_in_empty;
  logic        stream_in_valid;
  logic        stream_in_startofpacket;
  logic        stream_in_endofpacket;
  logic        stream_in_ready;
  logic [31:0] stream_out_data;
  logic [1:0]  stream_out_empty;
  logic        stream_out_valid;
  logic        stream_out_startofpacket;
  logic        stream_out_endofpacket;
  logic        stream_out_ready;
  logic [15:0] pkt_passed_count;
  logic [15:0] pkt_dropped_count;

  icmp_echo_filter #(.MAX_BYTES(128), .CNT_W(16)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .stream_in_data           (stream_in_data),
    .stream_in_empty          (stream_in_empty),
    .stream_in_valid          (stream_in_valid),
    .stream_in_startofpacket  (stream_in_startofpacket),
    .stream_in_endofpacket    (stream_in_endofpacket),
    .stream_in_ready          (stream_in_ready),
    .stream_out_data          (stream_out_data),
    .stream_out_empty         (stream_out_empty),
    .stream_out_valid         (stream_out_valid),
    .stream_out_startofpacket (stream_out_startofpacket),
    .stream_out_endofpacket   (stream_out_endofpacket),
    .stream_out_ready         (stream_out_ready),
    .pkt_passed_count         (pkt_passed_count),
    .pkt_dropped_count        (pkt_dropped_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  beat_t       exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [7:0]  pb [0:255];
  logic [31:0] pw [0:63];
  int          pkt_nw;
  logic [1:0]  pkt_emp;
  int          model_passed = 0;
  int          model_dropped = 0;
  bit          tog_en = 0;
  bit          in_tail = 0;
  int          out_cnt = 0;
  int          sop_cyc = 0;
  int          hdr5_cyc = 0;
  logic [31:0] sop_data = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (tog_en) begin
      #1;
      stream_out_ready = !stream_out_ready;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard: every output transfer must match the next expected beat.
  always @(negedge clk) begin
    beat_t got;
    beat_t want;
    if (reset_n && stream_out_valid && stream_out_ready) begin
      got.data  = stream_out_data;
      got.sop   = stream_out_startofpacket;
      got.eop   = stream_out_endofpacket;
      got.empty = stream_out_empty;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_out: got data=%h sop=%b eop=%b empty=%0d, expected no output",
                 got.data, got.sop, got.eop, got.empty);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          miscompares++;
          $display("FAIL out_word: got data=%h sop=%b eop=%b empty=%0d expected data=%h sop=%b eop=%b empty=%0d",
                   got.data, got.sop, got.eop, got.empty, want.data, want.sop, want.eop, want.empty);
        end else begin
          $display("out word %0d data=%h sop=%b eop=%b empty=%0d", out_cnt, got.data, got.sop, got.eop, got.empty);
        end
      end
      out_cnt++;
      if (stream_out_startofpacket) begin
        sop_cyc  = cyc;
        sop_data = stream_out_data;
      end
    end
    if (reset_n && in_tail && stream_out_valid && !stream_out_ready) begin
      vectors++;
      if (stream_in_ready) begin
        miscompares++;
        $display("FAIL in_ready_stall: got in_ready=1 expected 0 while output stalled");
      end
    end
  end

  // Builds a packet from IPv4/ICMP fields and records what the filter must do with it.
  task automatic new_pkt(input int nbytes, input logic [7:0] vihl, input logic [15:0] tlen,
                         input logic [7:0] proto, input logic [7:0] typ, input logic [7:0] seed);
    bit    pass;
    beat_t b;
    for (int i = 0; i < 256; i++) pb[i] = 8'(i * 7 + int'(seed));
    pb[0]  = vihl;
    pb[1]  = 8'h00;
    pb[2]  = tlen[15:8];
    pb[3]  = tlen[7:0];
    pb[9]  = proto;
    pb[20] = typ;
    pkt_nw  = (nbytes + 3) / 4;
    pkt_emp = 2'((4 - nbytes % 4) % 4);
    for (int k = 0; k < pkt_nw; k++)
      for (int j = 0; j < 4; j++)
        pw[k][8*j +: 8] = (4*k + j < nbytes) ? pb[4*k + j] : 8'h00;
    pass = (nbytes > 24) && (pb[0] == 8'h45) && ({pb[2], pb[3]} <= 16'd128)
        && (pb[9] == 8'd1) && (pb[20] == 8'd8);
    if (pass) begin
      for (int k = 0; k < pkt_nw; k++) begin
        b.data  = pw[k];
        b.sop   = (k == 0);
        b.eop   = (k == pkt_nw - 1);
        b.empty = (k == pkt_nw - 1) ? pkt_emp : 2'd0;
        exp_q.push_back(b);
      end
      model_passed++;
    end else begin
      model_dropped++;
    end
  endtask

  task automatic send_range(input int lo, input int hi, input bit drop_chk, input bit pass_chk);
    bit rdy;
    int tries;
    for (int k = lo; k <= hi; k++) begin
      stream_in_valid         = 1'b1;
      stream_in_data          = pw[k];
      stream_in_startofpacket = (k == 0);
      stream_in_endofpacket   = (k == pkt_nw - 1);
      stream_in_empty         = (k == pkt_nw - 1) ? pkt_emp : 2'd0;
      in_tail = pass_chk && (k >= 6);
      rdy = 1'b0;
      tries = 0;
      while (!rdy && tries < 200) begin
        @(negedge clk);
        rdy = stream_in_ready;
        @(posedge clk);
        #1;
        tries++;
      end
      in_tail = 1'b0;
      if (!rdy) begin
        vectors++;
        miscompares++;
        $display("FAIL in_timeout: word %0d got no in_ready within 200 cycles, required acceptance", k);
      end
      if (k == 5) hdr5_cyc = cyc;
      if (drop_chk && k >= 7) chk("drop_in_ready", tries, 1);
    end
    stream_in_valid         = 1'b0;
    stream_in_startofpacket = 1'b0;
    stream_in_endofpacket   = 1'b0;
    stream_in_empty         = 2'd0;
  endtask

  task automatic drain();
    int tries = 0;
    while ((exp_q.size() != 0 || stream_out_valid) && tries < 500) begin
      @(negedge clk);
      tries++;
    end
    repeat (3) @(posedge clk);
    #1;
    if (tries >= 500) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_passed"}, pkt_passed_count, model_passed);
    chk({tag, "_dropped"}, pkt_dropped_count, model_dropped);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    stream_in_valid = 1'b0;
    stream_in_data = 32'd0;
    stream_in_empty = 2'd0;
    stream_in_startofpacket = 1'b0;
    stream_in_endofpacket = 1'b0;
    stream_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", stream_out_valid, 0);
    chk("rst_in_ready", stream_in_ready, 0);
    chk("rst_passed", pkt_passed_count, 0);
    chk("rst_dropped", pkt_dropped_count, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", stream_in_ready, 1);

    // 84-byte echo request, output always ready
    out_cnt = 0;
    new_pkt(84, 8'h45, 16'd84, 8'd1, 8'd8, 8'd1);
    send_range(0, 20, 0, 1);
    drain();
    chk("t1_latency", sop_cyc - hdr5_cyc, 2);
    chk("t1_words", out_cnt, 21);
    chk("t1_word0", sop_data, 32'h5400_0045);
    chk("t1_passed_lit", pkt_passed_count, 1);
    chk("t1_dropped_lit", pkt_dropped_count, 0);
    chk_counts("t1");

    // same packet with downstream ready toggling every cycle
    out_cnt = 0;
    tog_en = 1'b1;
    new_pkt(84, 8'h45, 16'd84, 8'd1, 8'd8, 8'd2);
    send_range(0, 20, 0, 1);
    drain();
    tog_en = 1'b0;
    @(posedge clk);
    #2;
    stream_out_ready = 1'b1;
    chk("t2_words", out_cnt, 21);
    chk_counts("t2");

    // UDP packet then back-to-back echo request
    new_pkt(80, 8'h45, 16'd80, 8'd17, 8'd8, 8'd3);
    send_range(0, 19, 1, 0);
    new_pkt(84, 8'h45, 16'd84, 8'd1, 8'd8, 8'd4);
    send_range(0, 20, 0, 1);
    drain();
    chk("t3_dropped_lit", pkt_dropped_count, 1);
    chk_counts("t3");

    // oversize total_len, then echo reply
    new_pkt(84, 8'h45, 16'd200, 8'd1, 8'd8, 8'd5);
    send_range(0, 20, 1, 0);
    new_pkt(84, 8'h45, 16'd84, 8'd1, 8'd0, 8'd6);
    send_range(0, 20, 1, 0);
    drain();
    chk("t4_dropped_lit", pkt_dropped_count, 3);
    chk_counts("t4");

    // 4-word runt then a good packet
    new_pkt(16, 8'h45, 16'd16, 8'd1, 8'd8, 8'd7);
    send_range(0, 3, 0, 0);
    new_pkt(100, 8'h45, 16'd100, 8'd1, 8'd8, 8'd9);
    send_range(0, 24, 0, 1);
    drain();
    chk_counts("t5");

    // reset while the 10th output word is presented, upstream keeps sending the old packet
    new_pkt(84, 8'h45, 16'd84, 8'd1, 8'd8, 8'd10);
    send_range(0, 9, 0, 1);
    reset_n = 1'b0;
    exp_q.delete();
    model_passed = 0;
    model_dropped = 0;
    stream_in_valid = 1'b1;
    stream_in_data = pw[10];
    stream_in_startofpacket = 1'b0;
    stream_in_endofpacket = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_valid", stream_out_valid, 0);
    chk("t6_rst_data", stream_out_data, 0);
    chk("t6_rst_in_ready", stream_in_ready, 0);
    chk("t6_rst_passed", pkt_passed_count, 0);
    reset_n = 1'b1;
    send_range(10, 20, 0, 0);
    new_pkt(84, 8'h45, 16'd84, 8'd1, 8'd8, 8'd11);
    send_range(0, 20, 0, 1);
    drain();
    chk("t6_passed_lit", pkt_passed_count, 1);
    chk("t6_dropped_lit", pkt_dropped_count, 0);
    chk_counts("t6");
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
